// File: rtl/fsm_seq_pkg.sv
// Shared constants for the 13-state sequence detector and its stimulus driver.
// Detector state codes S1..S13, code width, script length and the stimulus FSM state type.
package fsm_seq_pkg;

  localparam int unsigned CODE_W = 17;
  localparam int unsigned NSTEPS = 12;

  localparam logic [CODE_W-1:0] S1  = 17'd0;
  localparam logic [CODE_W-1:0] S2  = 17'd200;
  localparam logic [CODE_W-1:0] S3  = 17'd700;
  localparam logic [CODE_W-1:0] S4  = 17'd900;
  localparam logic [CODE_W-1:0] S5  = 17'd1300;
  localparam logic [CODE_W-1:0] S6  = 17'd1800;
  localparam logic [CODE_W-1:0] S7  = 17'd2300;
  localparam logic [CODE_W-1:0] S8  = 17'd2800;
  localparam logic [CODE_W-1:0] S9  = 17'd3100;
  localparam logic [CODE_W-1:0] S10 = 17'd3400;
  localparam logic [CODE_W-1:0] S11 = 17'd3600;
  localparam logic [CODE_W-1:0] S12 = 17'd3800;
  localparam logic [CODE_W-1:0] S13 = 17'd4100;

  typedef enum logic [2:0] {
    StIdle,
    StDrive,
    StHold,
    StDone,
    StFail
  } stim_state_e;

endpackage

// File: rtl/fsm_seq_rom.sv
// Step -> {detector input vector, expected detector state code} lookup.
// Vector bit order is {i4, i3, i2, i1}. The expected-code table only exists when
// FSM_SEQ_STIM_CHECK_EN is defined; otherwise code reads as zero.
module fsm_seq_rom
  import fsm_seq_pkg::*;
(
  input  logic [3:0]        step,
  output logic [3:0]        vec,
  output logic [CODE_W-1:0] code
);

  // Stimulus vector for each script step
  always_comb begin
    vec = 4'b0000;
    case (step)
      4'd0:    vec = 4'b0100;
      4'd1:    vec = 4'b1001;
      4'd2:    vec = 4'b0000;
      4'd3:    vec = 4'b0010;
      4'd4:    vec = 4'b1111;
      4'd5:    vec = 4'b0100;
      4'd6:    vec = 4'b1001;
      4'd7:    vec = 4'b0000;
      4'd8:    vec = 4'b0100;
      4'd9:    vec = 4'b0100;
      4'd10:   vec = 4'b1001;
      4'd11:   vec = 4'b0000;
      default: vec = 4'b0000;
    endcase
  end

`ifdef FSM_SEQ_STIM_CHECK_EN
  // State code the detector must reach once step's vector has been applied
  always_comb begin
    code = '0;
    case (step)
      4'd0:    code = S2;
      4'd1:    code = S3;
      4'd2:    code = S4;
      4'd3:    code = S5;
      4'd4:    code = S6;
      4'd5:    code = S7;
      4'd6:    code = S8;
      4'd7:    code = S9;
      4'd8:    code = S10;
      4'd9:    code = S11;
      4'd10:   code = S12;
      4'd11:   code = S13;
      default: code = S1;
    endcase
  end
`else
  assign code = '0;
`endif

endmodule

// File: rtl/fsm_seq_stim.sv
// Stimulus driver that walks the 13-state sequence detector from s1 to s13.
// Optional macro FSM_SEQ_STIM_CHECK_EN: closed loop (waits on obs_state, timeout -> FAIL).
// Without it the script runs open loop: one DRIVE cycle per step, fail tied low.
module fsm_seq_stim #(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned HOLD    = 1,
  parameter int unsigned CODE_W  = 17
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [CODE_W-1:0] obs_state,
  output logic              i1,
  output logic              i2,
  output logic              i3,
  output logic              i4,
  output logic              busy,
  output logic              done,
  output logic              fail,
  output logic [3:0]        step
);

  import fsm_seq_pkg::*;

  localparam logic [3:0] HLAST = 4'(HOLD - 1);
  localparam logic [3:0] SLAST = 4'(NSTEPS - 1);

  stim_state_e state_q, state_d;
  logic [3:0]  step_q, step_d;
  logic [3:0]  vec_q, vec_d;
  logic [3:0]  hold_q, hold_d;
  logic        done_q, done_d;
  logic [3:0]  rom_vec;
  logic [16:0] rom_code;

  // ROM is addressed by the next step so the vector can be registered on entry to DRIVE
  fsm_seq_rom u_rom (
    .step (step_d),
    .vec  (rom_vec),
    .code (rom_code)
  );

`ifdef FSM_SEQ_STIM_CHECK_EN
  localparam int unsigned   TW    = $clog2(TIMEOUT) + 1;
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

  logic [TW-1:0] timer_q, timer_d;
  logic          fail_q, fail_d;
  logic          match;

  assign match = (obs_state == CODE_W'(rom_code));
`else
  logic unused_obs;
  localparam int unsigned unused_timeout = TIMEOUT;
  assign unused_obs = ^{obs_state, rom_code};
`endif

  // Step index: cleared by abort or accepted start, advanced when a hold completes
  always_comb begin
    step_d = step_q;
    if (abort) begin
      step_d = '0;
    end else if ((state_q inside {StIdle, StDone, StFail}) && start) begin
      step_d = '0;
    end else if (state_q == StHold && hold_q == HLAST && step_q != SLAST) begin
      step_d = step_q + 4'd1;
    end
  end

  // Next-state, counters and registered outputs
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    done_d  = 1'b0;
    vec_d   = 4'b0000;
`ifdef FSM_SEQ_STIM_CHECK_EN
    timer_d = timer_q;
    fail_d  = fail_q;
`endif
    if (abort) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle, StDone, StFail: begin
          if (start) begin
            state_d = StDrive;
`ifdef FSM_SEQ_STIM_CHECK_EN
            timer_d = '0;
            fail_d  = 1'b0;
`endif
          end
        end
        StDrive: begin
`ifdef FSM_SEQ_STIM_CHECK_EN
          // A match on the expiry cycle still wins
          if (match) begin
            state_d = StHold;
            hold_d  = '0;
          end else if (timer_q >= TLAST) begin
            state_d = StFail;
            fail_d  = 1'b1;
          end else if (timer_q != '1) begin
            timer_d = timer_q + 1'b1;
          end
`else
          state_d = StHold;
          hold_d  = '0;
`endif
        end
        StHold: begin
          if (hold_q == HLAST) begin
            if (step_q == SLAST) begin
              state_d = StDone;
              done_d  = 1'b1;
            end else begin
              state_d = StDrive;
`ifdef FSM_SEQ_STIM_CHECK_EN
              timer_d = '0;
`endif
            end
          end else begin
            hold_d = hold_q + 4'd1;
          end
        end
        default: state_d = StIdle;
      endcase
    end
    if (state_d inside {StDrive, StHold}) begin
      vec_d = rom_vec;
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      step_q  <= '0;
      vec_q   <= '0;
      hold_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      vec_q   <= vec_d;
      hold_q  <= hold_d;
      done_q  <= done_d;
    end
  end

`ifdef FSM_SEQ_STIM_CHECK_EN
  // Step timer and sticky fail flag
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      timer_q <= '0;
      fail_q  <= 1'b0;
    end else begin
      timer_q <= timer_d;
      fail_q  <= fail_d;
    end
  end

  assign fail = fail_q;
`else
  assign fail = 1'b0;
`endif

  assign {i4, i3, i2, i1} = vec_q;
  assign busy = (state_q == StDrive) || (state_q == StHold);
  assign done = done_q;
  assign step = step_q;

endmodule

// File: tb/tb_fsm_seq_stim.sv
// Self-checking bench for fsm_seq_stim. A behavioural responder plays the detector
// with random per-step latency; completion time is predicted from the latencies.
`timescale 1ns/1ps
module tb_fsm_seq_stim;

`ifdef FSM_SEQ_STIM_CHECK_EN
  localparam bit CHECK  = 1'b1;
  localparam int T_HOLD = 1;
`else
  localparam bit CHECK  = 1'b0;
  localparam int T_HOLD = 2;
`endif
  localparam int T_TIMEOUT = 16;

  typedef struct {
    int stuck_step;  // step given stuck_lat instead of a random latency (-1: none)
    int stuck_lat;
    int poke_step;   // step at which a stray start is pulsed (-1: none)
    bit exp_fail;
    int exp_step;
  } scen_t;

  logic        clk, reset, start, abort;
  logic [16:0] obs;
  logic        i1, i2, i3, i4, busy, done, fail;
  logic [3:0]  step;
  logic [3:0]  vec_o;

  int errors = 0;
  int checks = 0;

  logic [3:0]  script_vec  [12];
  logic [16:0] script_code [12];
  int          lat_cfg     [12];
  scen_t       tbl         [6];

  logic rsp_clr;
  int   pos, cnt;

  assign vec_o = {i4, i3, i2, i1};

  fsm_seq_stim #(
    .TIMEOUT (T_TIMEOUT),
    .HOLD    (T_HOLD),
    .CODE_W  (17)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .abort     (abort),
    .obs_state (obs),
    .i1        (i1),
    .i2        (i2),
    .i3        (i3),
    .i4        (i4),
    .busy      (busy),
    .done      (done),
    .fail      (fail),
    .step      (step)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Detector stand-in: advances one code after the expected vector is held lat_cfg cycles
  always @(posedge clk) begin
    if (rsp_clr) begin
      pos <= 0;
      cnt <= 0;
      obs <= '0;
    end else if (busy && pos < 12 && int'(step) == pos && vec_o == script_vec[pos]) begin
      if (cnt + 1 >= lat_cfg[pos]) begin
        obs <= script_code[pos];
        pos <= pos + 1;
        cnt <= 0;
      end else begin
        cnt <= cnt + 1;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic kick_start();
    @(negedge clk);
    rsp_clr = 1'b1;
    @(negedge clk);
    rsp_clr = 1'b0;
    start   = 1'b1;
    @(negedge clk);
    start   = 1'b0;
  endtask

  task automatic run_scen(input scen_t s);
    int  c, t_end, dones, exp_cycles, exp_st;
    bit  ended, poked, m_fail, exp_f;
    for (int k = 0; k < 12; k++) begin
      lat_cfg[k] = (k == s.stuck_step) ? s.stuck_lat : int'($urandom_range(1, 4));
    end
    // Completion time: each step costs (latency + 1) in DRIVE plus HOLD
    exp_cycles = 0;
    m_fail     = 1'b0;
    for (int k = 0; k < 12; k++) begin
      if (!m_fail) begin
        if (CHECK && lat_cfg[k] + 1 > T_TIMEOUT) begin
          m_fail     = 1'b1;
          exp_cycles += T_TIMEOUT;
        end else begin
          exp_cycles += (CHECK ? lat_cfg[k] + 1 : 1) + T_HOLD;
        end
      end
    end
    exp_f  = CHECK ? s.exp_fail : 1'b0;
    exp_st = CHECK ? s.exp_step : 11;

    kick_start();
    chk("start_busy", busy, 1);
    chk("start_fail_clear", fail, 0);
    chk("start_step", step, 0);
    chk("start_vec", vec_o, script_vec[0]);

    c = 0; t_end = 0; dones = 0; ended = 0; poked = 0;
    while (!ended && c < 600) begin
      @(negedge clk);
      c++;
      start = 1'b0;
      if (busy) chk("busy_vec", vec_o, script_vec[step]);
      if (done) begin dones++; ended = 1; t_end = c; end
      if (fail) begin ended = 1; t_end = c; end
      if (!poked && s.poke_step >= 0 && busy && int'(step) == s.poke_step) begin
        start = 1'b1;
        poked = 1'b1;
      end
    end
    checks++;
    if (!ended) begin
      errors++;
      $display("FAIL run_end: no done/fail within 600 cycles, step=%0d", step);
    end
    repeat (4) begin
      @(negedge clk);
      if (done) dones++;
    end
    chk("end_cycles", t_end, exp_cycles);
    chk("end_fail", fail, exp_f);
    chk("end_step", step, exp_st);
    chk("end_dones", dones, exp_f ? 0 : 1);
    chk("end_vec", vec_o, 0);
    chk("end_busy", busy, 0);
  endtask

  task automatic run_interrupt(input int at_step, input bit use_reset);
    int c, dones, busy_cnt;
    bit hit;
    for (int k = 0; k < 12; k++) lat_cfg[k] = int'($urandom_range(1, 4));
    kick_start();
    hit = 0; c = 0;
    while (!hit && c < 400) begin
      @(negedge clk);
      c++;
      if (busy && int'(step) == at_step) hit = 1'b1;
    end
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL reach_step: step %0d never seen, step=%0d", at_step, step);
      return;
    end
    if (use_reset) begin
      #2 reset = 1'b0;
      #1;
      chk("rst_vec", vec_o, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_fail", fail, 0);
      chk("rst_step", step, 0);
      @(negedge clk);
      reset = 1'b1;
    end else begin
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk("abort_busy", busy, 0);
      chk("abort_step", step, 0);
      chk("abort_vec", vec_o, 0);
      chk("abort_done", done, 0);
      chk("abort_fail", fail, 0);
    end
    dones = 0; busy_cnt = 0;
    repeat (30) begin
      @(negedge clk);
      if (done) dones++;
      if (busy) busy_cnt++;
    end
    chk("idle_no_done", dones, 0);
    chk("idle_no_busy", busy_cnt, 0);
    chk("idle_step", step, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    script_vec  = '{4'b0100, 4'b1001, 4'b0000, 4'b0010, 4'b1111, 4'b0100,
                    4'b1001, 4'b0000, 4'b0100, 4'b0100, 4'b1001, 4'b0000};
    script_code = '{17'd200, 17'd700, 17'd900, 17'd1300, 17'd1800, 17'd2300,
                    17'd2800, 17'd3100, 17'd3400, 17'd3600, 17'd3800, 17'd4100};
    for (int k = 0; k < 12; k++) lat_cfg[k] = 1;
    //          stuck  lat poke fail step
    tbl[0] = '{-1,    0,  -1,  1'b0, 11};  // plain random-latency run
    tbl[1] = '{ 1,   99,  -1,  1'b1,  1};  // detector stuck after step 0
    tbl[2] = '{-1,    0,   3,  1'b0, 11};  // restart after fail, stray start at step 3
    tbl[3] = '{ 6,   15,  -1,  1'b0, 11};  // match lands on the timer-expiry cycle
    tbl[4] = '{ 6,   16,  -1,  1'b1,  6};  // one cycle too late
    tbl[5] = '{-1,    0,   0,  1'b0, 11};  // stray start on the first step

    reset = 1'b0; start = 1'b0; abort = 1'b0; rsp_clr = 1'b1;
    #1;
    chk("reset_vec", vec_o, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_fail", fail, 0);
    chk("reset_step", step, 0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_busy", busy, 0);

    for (int i = 0; i < 6; i++) run_scen(tbl[i]);

`ifdef FSM_SEQ_STIM_CHECK_EN
    // abort out of FAIL leaves the sticky flag alone
    run_scen(tbl[1]);
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_keeps_fail", fail, 1);
    chk("abort_from_fail_step", step, 0);
`endif

    run_interrupt(5, 1'b0);
    run_interrupt(7, 1'b1);
    run_scen(tbl[0]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fsm_seq_stim.md
Name: fsm_seq_stim

Overview:
- Drives the 4-bit input vector of the 13-state sequence detector (codes 0, 200, 700, 900, 1300, 1800, 2300, 2800, 3100, 3400, 3600, 3800, 4100) so that it walks s1 to s13.
- Replays a fixed 12-step vector script. Each step waits for the detector's 17-bit state code to confirm before advancing.
- Sits beside the detector in the FSM test harness; start/busy/done/fail handshake towards the harness controller.

Parameters:
- TIMEOUT, 16: max cycles per step waiting for the expected state code before failing.
- HOLD, 1: cycles each vector is held after confirmation before the next step's vector is driven (1..15).
- CODE_W, 17: width of the observed state code.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- start  in  1  one-cycle pulse; accepted only in IDLE, DONE or FAIL.
- abort  in  1  level; forces IDLE next cycle from any state.
- obs_state  in  CODE_W  detector state code.
- i1, i2, i3, i4  out  1 each  detector inputs.
- busy  out  1  high in DRIVE and HOLD.
- done  out  1  one-cycle pulse on completion.
- fail  out  1  sticky high in FAIL until next accepted start or reset.
- step  out  4  current step index 0..11.

Behaviour:
- Reset (reset=0, async): state IDLE; i1..i4=0, busy=0, done=0, fail=0, step=0.
- Script, step k: vector {i4,i3,i2,i1} / expected code.
  - 0: 0100 / 200
  - 1: 1001 / 700
  - 2: 0000 / 900
  - 3: 0010 / 1300
  - 4: 1111 / 1800
  - 5: 0100 / 2300
  - 6: 1001 / 2800
  - 7: 0000 / 3100
  - 8: 0100 / 3400
  - 9: 0100 / 3600
  - 10: 1001 / 3800
  - 11: 0000 / 4100
- States: IDLE, DRIVE, HOLD, DONE, FAIL.
- IDLE, DONE or FAIL + start: next cycle DRIVE, step=0, timer=0, fail cleared.
- DRIVE:
  - Outputs = vector[step], registered, valid the cycle after entry.
  - Each cycle with obs_state != expected[step]: timer increments.
  - timer reaches TIMEOUT-1 without a match: FAIL; outputs forced to 0000; step frozen for debug.
  - obs_state == expected[step]: HOLD, hold counter=0.
- HOLD:
  - Vector unchanged for HOLD cycles.
  - Then, if step==11: DONE with done pulsed for 1 cycle and outputs 0000.
  - Otherwise: step+1, timer=0, DRIVE.
- DONE: idle-like; outputs 0000; step stays 11.
- Simultaneous events:
  - abort has priority over match, timeout and start.
  - A match on the same cycle as timer expiry counts as a match.
  - start while busy is ignored.
- abort: IDLE, outputs 0000, step=0, no done, fail unchanged.
- Reset mid-sequence: immediate return to reset values; no done.
- Timer is $clog2(TIMEOUT)+1 bits wide and saturates; it never wraps.

Optional Feature:
- Macro: FSM_SEQ_STIM_CHECK_EN.
- Defined (closed loop): behaviour as above; obs_state compared, timeout and FAIL active.
- Undefined (open loop):
  - obs_state ignored; the expected-code table is not built.
  - DRIVE lasts exactly 1 cycle, then HOLD.
  - fail is tied 0 and FAIL is unreachable.
  - Sequence always completes in 12*(1+HOLD) cycles after start.

Decomposition:
- Shared package fsm_seq_pkg:
  - Detector state-code constants S1..S13 (0..4100) and CODE_W.
  - Step count NSTEPS=12.
  - Stimulus state enum.
- The same constants are reused by the detector's bench.
- One sub-module: fsm_seq_rom, a combinational step -> {vector, expected code} lookup.

Test Plan:
- Closed loop, HOLD=1, real detector attached; start pulse -> vectors 0100, 1001, 0000, 0010, ... in order; obs_state reaches 4100; done pulses once; fail=0; step=11.
- obs_state stuck at 200 after step 1 -> after 16 cycles fail=1, state FAIL, step=1, i1..i4=0000; a new start clears fail and restarts at step 0.
- abort asserted while step=5 -> next cycle IDLE, busy=0, step=0, outputs 0000, no done.
- reset=0 pulsed mid-step 7 -> all outputs 0 asynchronously; after release, start is required and the sequence begins from step 0.
- start pulsed while busy at step 3 -> ignored; sequence continues uninterrupted; exactly one done.
- FSM_SEQ_STIM_CHECK_EN undefined, HOLD=2, obs_state tied 0 -> done 36 cycles after start; fail never asserted.
